trap_csr_unit: RTL
==================

Name: trap_csr_unit

Overview:
Parametrised machine-mode trap and CSR unit for the RV64 core.
- Holds mstatus, mie, mip, mtvec, mepc, mcause, mtval and mscratch.
- Latches NUM_IRQ external interrupt sources; each source is individually edge- or level-sensitive.
- Arbitrates exceptions, interrupts and mret, and issues one registered PC redirect plus a per-source acknowledge.
- Sits beside the EXE stage. The core supplies instruction-boundary, CSR-access and exception information; the unit returns read data and redirects.

Parameters:
XLEN, 64, register width (32 or 64).
NUM_IRQ, 4, external sources (1..XLEN-16), mapped to mip/mie bits [16+i].
EDGE_MASK, 4'b0001, bit i=1: source i is rising-edge sensitive; bit i=0: source i is level sensitive.
MTVEC_RESET, 64'h0, reset value of mtvec.
RESET_MIE, 1, reset value of mstatus.MIE.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
irq_src  in  NUM_IRQ  raw interrupt lines
irq_ack  out  NUM_IRQ  one-hot pulse for the source taken
boundary_valid  in  1  EXE at instruction boundary; interrupt may be taken
boundary_pc  in  XLEN  PC of the instruction not yet executed
exc_valid  in  1  synchronous exception this cycle
exc_cause  in  6  exception code
exc_pc  in  XLEN  faulting PC
exc_tval  in  XLEN  trap value
mret  in  1  mret executing
csr_en  in  1  CSR instruction executing
csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_addr  in  12  CSR index
csr_wdata  in  XLEN  write/mask operand
csr_rdata  out  XLEN  combinational old value
csr_illegal  out  1  combinational; address unimplemented
redirect_valid  out  1  one-cycle pulse
redirect_pc  out  XLEN  target PC
mstatus_mie  out  1  current MIE

Behaviour:
Reset:
- All outputs 0, except mstatus_mie=RESET_MIE.
- mstatus = {MPP=2'b11, MIE=RESET_MIE, others 0}; mtvec=MTVEC_RESET; all other CSRs and pending state 0.
- Reset mid-redirect cancels the pulse.

Pending:
- Edge sources: pend[i] sets on a 0->1 transition of registered irq_src[i]. It clears when that source is taken, or on a CSR write to mip with bit 16+i = 0.
- Level sources: pend[i] = registered irq_src[i]. Writes to mip are ignored.
- mip[16+i] reads pend[i]. mip[11] (MEIP) reads |(pend & mie[16+:NUM_IRQ]).

Priority per cycle (highest first):
1. exc_valid: mepc<=exc_pc & ~3; mcause<={0,exc_cause}; mtval<=exc_tval.
2. Interrupt: taken when boundary_valid & MIE & |(pend&mie). Lowest index i wins. mepc<=boundary_pc & ~3; mcause<={1'b1, 16+i}; mtval<=0; irq_ack[i] pulses.
3. mret: redirect_pc<=mepc; MIE<=MPIE; MPIE<=1.
4. CSR access.
- Cases 1 and 2 both set MPIE<=MIE, MIE<=0 and redirect to the trap vector.
- Any taken trap or mret suppresses a same-cycle CSR write and any lower-priority event. A pending interrupt stays latched.

Trap vector (mtvec MODE = bits[1:0]):
- Direct (0): target = BASE.
- Vectored (1): interrupts target BASE + 4*cause_code; exceptions target BASE.
- Writes of MODE 2 or 3 keep the old MODE; BASE is always written.

Redirect timing:
- Event in cycle N -> redirect_valid=1 and redirect_pc in cycle N+1. irq_ack pulses in cycle N+1.
- CSR updates are visible from cycle N+1.
- The core bubbles one cycle after a redirect.

CSR access:
- rdata returns the pre-write value.
- New value: RW = wdata; RS = old|wdata; RC = old&~wdata. op 00 performs no write.
- Writable fields: mstatus MIE/MPIE only; mie bits[16+:NUM_IRQ] and bit 11; mepc with bits[1:0] forced 0; mcause, mtval, mscratch fully writable.
- Unknown address: csr_illegal=1, rdata=0, no write.

Width: all PC arithmetic is modulo 2^XLEN.

Decomposition:
- Package trap_pkg: CSR address constants (0x300, 0x304, 0x305, 0x340-0x344), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), csr_op encoding, mcause interrupt-bit position, cause code for the first local interrupt (16).
- Sub-module irq_pend_prio: input registering, edge detect, pend latch, lowest-index priority encoder. Outputs any_req, req_idx, one-hot ack.

Test Plan:
1. Reset with MTVEC_RESET=0x100 -> mtvec reads 0x100, mstatus reads 0x1808, csr_illegal=0 at 0x300.
2. irq_src[2] level high, mie[18]=1, boundary_pc=0x8000_0010 -> next cycle: redirect_pc=0x100 (direct), mepc=0x8000_0010, mcause=0x8000_0000_0000_0012, irq_ack=4'b0100, MIE=0, MPIE=1.
3. Vectored mtvec=0x201, edge source 0 pulsed -> redirect_pc=0x240; pend[0] clears; a second take happens only after a new rising edge.
4. Sources 1 and 3 pending, exc_valid same cycle with cause 2 -> exception wins (mcause=2, redirect=BASE, no irq_ack); after mret, source 1 is taken before source 3.
5. CSR RS/RC on mie (set 0x30000, clear 0x10000) -> mie=0x20000. Write mepc=0x1003 -> reads 0x1000. Write mtvec MODE=3 -> MODE keeps old value. Address 0x7C0 -> csr_illegal=1.
6. mret with MPIE=1 and CSR write in the same cycle -> MIE=1, redirect_pc=mepc, CSR write dropped.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap and CSR unit.
// CSR map, mstatus fields, CSR op encoding, interrupt cause numbering.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam int MS_MIE  = 3;
  localparam int MS_MPIE = 7;
  localparam int MS_MPP  = 11;

  localparam int MEIP_BIT       = 11;
  localparam int LOCAL_IRQ_BASE = 16;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  function automatic int irq_flag_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/irq_pend_prio.sv
// Interrupt source sampling, edge/level pending latch, lowest-index pick.
// Ports: irq_src raw lines, irq_en mask, take/clear controls; pend, any_req, req_idx, ack.
module irq_pend_prio #(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = NUM_IRQ'(1),
  parameter int                 IW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               take,
  input  logic               clr_we,
  input  logic [NUM_IRQ-1:0] clr_keep,
  output logic [NUM_IRQ-1:0] pend,
  output logic               any_req,
  output logic [IW-1:0]      req_idx,
  output logic [NUM_IRQ-1:0] ack
);

  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] src_qq;
  logic [NUM_IRQ-1:0] pend_r;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] req;

  assign clr = (take ? ack : '0)
             | (clr_we ? ~clr_keep : '0);

  // A new edge beats a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      src_qq <= '0;
      pend_r <= '0;
    end else begin
      src_q  <= irq_src;
      src_qq <= src_q;
      pend_r <= EDGE_MASK
              & ((pend_r & ~clr) | (src_q & ~src_qq));
    end
  end

  assign pend    = (EDGE_MASK & pend_r) | (~EDGE_MASK & src_q);
  assign req     = pend & irq_en;
  assign any_req = |req;

  // Descending scan: the last hit written is the lowest index.
  always_comb begin
    req_idx = '0;
    ack     = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        req_idx = IW'(i);
        ack     = NUM_IRQ'(1) << i;
      end
    end
  end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: CSR file, trap arbitration, registered redirect.
// Ports: irq_src/irq_ack, boundary/exc/mret events, CSR access, redirect, mstatus_mie.
module trap_csr_unit
  import trap_pkg::*;
#(
  parameter int                 XLEN        = 64,
  parameter int                 NUM_IRQ     = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = NUM_IRQ'(1),
  parameter logic [XLEN-1:0]    MTVEC_RESET = '0,
  parameter logic               RESET_MIE   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               boundary_valid,
  input  logic [XLEN-1:0]    boundary_pc,
  input  logic               exc_valid,
  input  logic [5:0]         exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret,
  input  logic               csr_en,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               mstatus_mie
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [XLEN-1:0] MIE_MASK =
    (XLEN'({NUM_IRQ{1'b1}}) << LOCAL_IRQ_BASE)
    | (XLEN'(1) << MEIP_BIT);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mepc_q;
  logic [XLEN-1:0] mcause_q, mtval_q, mscratch_q;

  logic [NUM_IRQ-1:0] pend, ack;
  logic               any_req;
  logic [IW-1:0]      req_idx;

  logic [XLEN-1:0] mstatus_v, mip_v, wval;
  logic [XLEN-1:0] base, irq_code, irq_target;
  logic            hit, csr_we;
  logic            take_exc, take_irq, take_mret;
  csr_op_e         op;

  assign op = csr_op_e'(csr_op);

  assign take_exc  = exc_valid;
  assign take_irq  = !exc_valid && boundary_valid
                  && st_mie && any_req;
  assign take_mret = !exc_valid && !take_irq && mret;
  assign csr_we    = csr_en && op != OP_NONE && hit
                  && !(take_exc || take_irq || take_mret);

  irq_pend_prio #(
    .NUM_IRQ   (NUM_IRQ),
    .EDGE_MASK (EDGE_MASK),
    .IW        (IW)
  ) u_irq (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .irq_en   (mie_q[LOCAL_IRQ_BASE +: NUM_IRQ]),
    .take     (take_irq),
    .clr_we   (csr_we && csr_addr == CSR_MIP),
    .clr_keep (wval[LOCAL_IRQ_BASE +: NUM_IRQ]),
    .pend     (pend),
    .any_req  (any_req),
    .req_idx  (req_idx),
    .ack      (ack)
  );

  always_comb begin
    mstatus_v              = '0;
    mstatus_v[MS_MPP +: 2] = 2'b11;
    mstatus_v[MS_MIE]      = st_mie;
    mstatus_v[MS_MPIE]     = st_mpie;
    mip_v                  = '0;
    mip_v[LOCAL_IRQ_BASE +: NUM_IRQ] = pend;
    mip_v[MEIP_BIT] = |(pend & mie_q[LOCAL_IRQ_BASE +: NUM_IRQ]);
  end

  always_comb begin
    csr_rdata = '0;
    hit       = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_v;
      CSR_MIE:      csr_rdata = mie_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = mip_v;
      default:      hit = 1'b0;
    endcase
  end

  assign csr_illegal = csr_en && !hit;

  always_comb begin
    case (op)
      OP_RW:   wval = csr_wdata;
      OP_RS:   wval = csr_rdata | csr_wdata;
      OP_RC:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  assign base       = mtvec_q & ALIGN;
  assign irq_code   = XLEN'(LOCAL_IRQ_BASE) + XLEN'(req_idx);
  assign irq_target = (mtvec_q[1:0] == 2'b01)
                    ? base + (irq_code << 2) : base;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie         <= RESET_MIE;
      st_mpie        <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mscratch_q     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      irq_ack        <= '0;
    end else begin
      redirect_valid <= take_exc || take_irq || take_mret;
      irq_ack        <= take_irq ? ack : '0;
      unique case (1'b1)
        take_exc: begin
          mepc_q      <= exc_pc & ALIGN;
          mcause_q    <= XLEN'(exc_cause);
          mtval_q     <= exc_tval;
          st_mpie     <= st_mie;
          st_mie      <= 1'b0;
          redirect_pc <= base;
        end
        take_irq: begin
          mepc_q      <= boundary_pc & ALIGN;
          mcause_q    <= irq_code
                       | (XLEN'(1) << irq_flag_bit(XLEN));
          mtval_q     <= '0;
          st_mpie     <= st_mie;
          st_mie      <= 1'b0;
          redirect_pc <= irq_target;
        end
        take_mret: begin
          redirect_pc <= mepc_q;
          st_mie      <= st_mpie;
          st_mpie     <= 1'b1;
        end
        csr_we: begin
          case (csr_addr)
            CSR_MSTATUS: begin
              st_mie  <= wval[MS_MIE];
              st_mpie <= wval[MS_MPIE];
            end
            CSR_MIE:      mie_q <= wval & MIE_MASK;
            CSR_MTVEC:    mtvec_q <= {wval[XLEN-1:2],
                            wval[1] ? mtvec_q[1:0] : wval[1:0]};
            CSR_MSCRATCH: mscratch_q <= wval;
            CSR_MEPC:     mepc_q <= wval & ALIGN;
            CSR_MCAUSE:   mcause_q <= wval;
            CSR_MTVAL:    mtval_q <= wval;
            default:      ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mstatus_mie = st_mie;

endmodule
